pipeline_hazard_ctrl: RTL and testbench

//   Hazard and stall controller that sequences the IF/ID pipeline register, the PC and the downstream stages.

---
 rtl/pipeline_hazard_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the IF/ID register, PC and downstream stages.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] IF_ID_rs_i,
  input  logic [REG_ADDR_W-1:0] IF_ID_rt_i,
  input  logic [REG_ADDR_W-1:0] ID_EX_rt_i,
  input  logic                  ID_EX_memread_i,
  input  logic                  branch_taken_i,
  input  logic                  jump_i,
  input  logic                  dmem_req_i,
  input  logic                  dmem_ack_i,
  output logic                  PC_write_o,
  output logic                  IF_ID_write_o,
  output logic                  IF_ID_flush_o,
  output logic                  ID_EX_bubble_o,
  output logic                  pipe_freeze_o,
  output logic                  err_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o,
  output logic [CNT_W-1:0]      wait_cnt_o
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR      = 2'd2;

  localparam int unsigned TMR_W    = 8;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timer_nxt;

  logic w_hazard_lu;
  logic w_redirect;
  logic w_mem_miss;

  // RUN-state decode with the memory miss already excluded
  logic w_run_pc_write;
  logic w_run_if_id_write;
  logic w_run_flush;
  logic w_run_bubble;

  logic w_pc_write;
  logic w_if_id_write;
  logic w_flush;
  logic w_bubble;
  logic w_freeze;

  assign w_hazard_lu = ID_EX_memread_i && (ID_EX_rt_i != '0) &&
                       ((ID_EX_rt_i == IF_ID_rs_i) || (ID_EX_rt_i == IF_ID_rt_i));
  assign w_redirect  = branch_taken_i | jump_i;
  assign w_mem_miss  = dmem_req_i & ~dmem_ack_i;

  // Load-use outranks redirect: branch operands are not valid until the stall resolves.
  always_comb begin
    w_run_pc_write    = 1'b1;
    w_run_if_id_write = 1'b1;
    w_run_flush       = 1'b0;
    w_run_bubble      = 1'b0;
    if (w_hazard_lu) begin
      w_run_pc_write    = 1'b0;
      w_run_if_id_write = 1'b0;
      w_run_bubble      = 1'b1;
    end else if (w_redirect) begin
      w_run_flush = 1'b1;
    end
  end

  always_comb begin
    w_pc_write    = 1'b0;
    w_if_id_write = 1'b0;
    w_flush       = 1'b0;
    w_bubble      = 1'b0;
    w_freeze      = 1'b1;
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;

    case (r_state)
      ST_RUN: begin
        if (w_mem_miss) begin
          w_state_nxt = ST_MEM_WAIT;
          w_timer_nxt = TMR_W'(1);
        end else begin
          w_pc_write    = w_run_pc_write;
          w_if_id_write = w_run_if_id_write;
          w_flush       = w_run_flush;
          w_bubble      = w_run_bubble;
          w_freeze      = 1'b0;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ack_i) begin
          w_pc_write    = w_run_pc_write;
          w_if_id_write = w_run_if_id_write;
          w_flush       = w_run_flush;
          w_bubble      = w_run_bubble;
          w_freeze      = 1'b0;
          w_state_nxt   = ST_RUN;
          w_timer_nxt   = '0;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
          if (r_timer == TMR_LAST) begin
            w_state_nxt = ST_ERR;
          end
        end
      end
      ST_ERR: begin
        w_state_nxt = ST_ERR;
      end
      default: begin
        // Illegal encoding: hold the pipeline one cycle and recover to RUN.
        w_state_nxt = ST_RUN;
        w_timer_nxt = '0;
      end
    endcase

    if (rst_i) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_flush       = 1'b0;
      w_bubble      = 1'b1;
      w_freeze      = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_RUN;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  assign PC_write_o     = w_pc_write;
  assign IF_ID_write_o  = w_if_id_write;
  assign IF_ID_flush_o  = w_flush;
  assign ID_EX_bubble_o = w_bubble;
  assign pipe_freeze_o  = w_freeze;
  assign err_o          = (r_state == ST_ERR);

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_lu_stall;

  // Outside reset the bubble is only ever raised by a load-use stall.
  assign w_lu_stall = w_bubble & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      if (w_lu_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
      if ((r_state == ST_MEM_WAIT) && (r_wait_cnt != '1)) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
  assign wait_cnt_o  = r_wait_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
  assign wait_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; outputs packed as {pc,ifid,flush,bubble,freeze}.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 32;

  localparam logic [4:0] O_RST    = 5'b00010;
  localparam logic [4:0] O_RUN    = 5'b11000;
  localparam logic [4:0] O_STALL  = 5'b00010;
  localparam logic [4:0] O_FLUSH  = 5'b11100;
  localparam logic [4:0] O_FREEZE = 5'b00001;

  logic          clk;
  logic          rst;
  logic [AW-1:0] if_rs;
  logic [AW-1:0] if_rt;
  logic [AW-1:0] ex_rt;
  logic          memread;
  logic          br;
  logic          jmp;
  logic          req;
  logic          ack;
  logic          pc_w;
  logic          ifid_w;
  logic          flush;
  logic          bubble;
  logic          freeze;
  logic          err;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
  logic [CW-1:0] wait_cnt;

  int n_total;
  int n_bad;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W (AW),
    .MEM_TIMEOUT(4),
    .CNT_W      (CW)
  ) u_dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .IF_ID_rs_i     (if_rs),
    .IF_ID_rt_i     (if_rt),
    .ID_EX_rt_i     (ex_rt),
    .ID_EX_memread_i(memread),
    .branch_taken_i (br),
    .jump_i         (jmp),
    .dmem_req_i     (req),
    .dmem_ack_i     (ack),
    .PC_write_o     (pc_w),
    .IF_ID_write_o  (ifid_w),
    .IF_ID_flush_o  (flush),
    .ID_EX_bubble_o (bubble),
    .pipe_freeze_o  (freeze),
    .err_o          (err),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt),
    .wait_cnt_o     (wait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic m, input int unsigned ert, input int unsigned rs,
                     input int unsigned rt, input logic b, input logic j,
                     input logic rq, input logic ak);
    memread = m;
    ex_rt   = AW'(ert);
    if_rs   = AW'(rs);
    if_rt   = AW'(rt);
    br      = b;
    jmp     = j;
    req     = rq;
    ack     = ak;
  endtask

  // Check the Mealy outputs and err for the current cycle, then advance one clock.
  task automatic cyc(input string tag, input logic [4:0] exp_o, input logic exp_err);
    #2;
    chk(tag, {27'd0, pc_w, ifid_w, flush, bubble, freeze}, {27'd0, exp_o});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    // T1 reset
    cyc("rst0", O_RST, 1'b0);
    cyc("rst1", O_RST, 1'b0);
    rst = 1'b0;
    cyc("run_dflt", O_RUN, 1'b0);

    // T2 load-use
    drv(1, 5, 5, 0, 0, 0, 0, 0);
    cyc("lu_rs", O_STALL, 1'b0);
    drv(0, 5, 5, 0, 0, 0, 0, 0);
    cyc("lu_clear", O_RUN, 1'b0);
    drv(1, 7, 1, 7, 0, 0, 0, 0);
    cyc("lu_rt", O_STALL, 1'b0);
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    cyc("lu_r0", O_RUN, 1'b0);
    drv(1, 6, 5, 4, 0, 0, 0, 0);
    cyc("lu_nomatch", O_RUN, 1'b0);

    // T3 redirect
    drv(0, 0, 0, 0, 1, 0, 0, 0);
    cyc("br", O_FLUSH, 1'b0);
    drv(0, 0, 0, 0, 0, 1, 0, 0);
    cyc("jmp", O_FLUSH, 1'b0);
    drv(1, 3, 3, 0, 1, 0, 0, 0);
    cyc("br_lu", O_STALL, 1'b0);

    // T4 memory wait, ack on fourth cycle along with a taken branch
    drv(0, 0, 0, 0, 0, 0, 1, 0);
    cyc("miss0", O_FREEZE, 1'b0);
    cyc("wait1", O_FREEZE, 1'b0);
    drv(0, 0, 0, 0, 1, 0, 1, 0);
    cyc("wait2_br", O_FREEZE, 1'b0);
    drv(0, 0, 0, 0, 1, 0, 1, 1);
    cyc("ack_br", O_FLUSH, 1'b0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef PIPE_CTRL_PERF_EN
    chk("wait_cnt", wait_cnt, 32'd3);
    chk("stall_cnt", stall_cnt, 32'd3);
    chk("flush_cnt", flush_cnt, 32'd3);
`endif
    cyc("after_ack", O_RUN, 1'b0);
    drv(0, 0, 0, 0, 0, 0, 0, 1);
    cyc("ack_no_req", O_RUN, 1'b0);
    drv(0, 0, 0, 0, 0, 0, 1, 1);
    cyc("req_ack", O_RUN, 1'b0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    cyc("req_ack_next", O_RUN, 1'b0);

    // T6 miss outranks hazard and redirect; ack cycle then honours the hazard
    drv(1, 9, 9, 0, 1, 0, 1, 0);
    cyc("simul", O_FREEZE, 1'b0);
    drv(1, 9, 9, 0, 0, 0, 1, 1);
    cyc("ack_lu", O_STALL, 1'b0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    cyc("simul_done", O_RUN, 1'b0);

    // Reset while in MEM_WAIT drops the access
    drv(0, 0, 0, 0, 0, 0, 1, 0);
    cyc("rw_miss", O_FREEZE, 1'b0);
    rst = 1'b1;
    cyc("rw_rst", O_RST, 1'b0);
    rst = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    cyc("rw_run", O_RUN, 1'b0);

    // T5 timeout with MEM_TIMEOUT=4
    drv(0, 0, 0, 0, 0, 0, 1, 0);
    cyc("to0", O_FREEZE, 1'b0);
    cyc("to1", O_FREEZE, 1'b0);
    cyc("to2", O_FREEZE, 1'b0);
    cyc("to3", O_FREEZE, 1'b0);
    cyc("err0", O_FREEZE, 1'b1);
    drv(0, 0, 0, 0, 1, 0, 0, 1);
    cyc("err_hold", O_FREEZE, 1'b1);
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("err_rst_out", {27'd0, pc_w, ifid_w, flush, bubble, freeze}, {27'd0, O_RST});
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("err_cleared", O_RUN, 1'b0);

`ifndef PIPE_CTRL_PERF_EN
    chk("stall_cnt0", stall_cnt, 32'd0);
    chk("flush_cnt0", flush_cnt, 32'd0);
    chk("wait_cnt0", wait_cnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
